// File: rtl/rv32m_issue_ctrl_pkg.sv
// Shared encodings for the RV32M issue controller: func3 values, FSM states
// and the rule deciding which back-to-back M ops the unit can fuse.
package rv32m_issue_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_t;

  // A high-half multiply leaves the low half in the array; a divide leaves the remainder.
  function automatic logic is_fuse_pair(input logic [2:0] prev, input logic [2:0] cur);
    logic mulh_mul;
    mulh_mul = ((prev == F3_MULH) || (prev == F3_MULHSU) || (prev == F3_MULHU)) && (cur == F3_MUL);
    return mulh_mul || ((prev == F3_DIV) && (cur == F3_REM)) || ((prev == F3_DIVU) && (cur == F3_REMU));
  endfunction

endpackage

// File: rtl/rv32m_fuse_pred.sv
// Record of the last unfused M op plus the fusable compare against the op in ID.
// Standalone so the ALU side can apply the same prediction rule.
module rv32m_fuse_pred
  import rv32m_issue_ctrl_pkg::*;
#(
  parameter bit ENABLE_FUSE = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       inv,
  input  logic [2:0] func3,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       fusable
);

  logic       rec_valid;
  logic [2:0] rec_func3;
  logic [4:0] rec_rs1;
  logic [4:0] rec_rs2;
  logic [4:0] rec_rd;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rec_valid <= 1'b0;
      rec_func3 <= 3'b000;
      rec_rs1   <= 5'd0;
      rec_rs2   <= 5'd0;
      rec_rd    <= 5'd0;
    end else if (inv) begin
      rec_valid <= 1'b0;
    end else if (load) begin
      rec_valid <= 1'b1;
      rec_func3 <= func3;
      rec_rs1   <= rs1;
      rec_rs2   <= rs2;
      rec_rd    <= rd;
    end
  end

  // The first op must not have overwritten either source the second op reads.
  assign fusable = ENABLE_FUSE && rec_valid &&
                   (rec_rs1 == rs1) && (rec_rs2 == rs2) &&
                   (rec_rd != rec_rs1) && (rec_rd != rec_rs2) &&
                   is_fuse_pair(rec_func3, func3);

endmodule

// File: rtl/rv32m_issue_ctrl.sv
// Issue-side controller for the fused RV32M mul/div unit: captures M ops from ID,
// starts the divider, stalls IF/ID while the unit works, predicts fused pairs.
module rv32m_issue_ctrl
  import rv32m_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          ENABLE_FUSE = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       id_valid,
  input  logic       id_rv32m,
  input  logic [2:0] id_func3,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       flush,
  input  logic       ex_ready,
  input  logic       ex_fuse,
  output logic       e_rv32m,
  output logic [2:0] e_func3,
  output logic       estart_sdivide,
  output logic       estart_udivide,
  output logic       stall,
  output logic       fuse_hint,
  output logic       mismatch,
  output logic       timeout
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wd_cnt;
  logic       in_wait;
  logic       accept;
  logic       fusable;
  logic       wd_fire;
  logic       rec_load;
  logic       rec_inv;
  logic       fuse_sample;

  assign in_wait = (state != ST_IDLE);
  assign stall   = in_wait & ~ex_ready;

  // Handshake: id_valid&id_rv32m is the offer, ~stall the ready; the op is taken
  // in the cycle both hold and flush is low. ex_ready is a one-cycle completion
  // strobe honoured only in a wait state, so completion and the next accept may
  // share a cycle.
  assign accept  = id_valid & id_rv32m & ~stall & ~flush;
  assign wd_fire = stall & (wd_cnt == WD_LAST);
  assign timeout = wd_fire;

  assign fuse_sample = (in_wait & ex_ready) | (e_rv32m & fuse_hint);
  assign mismatch    = fuse_sample & (ex_fuse ^ fuse_hint);

  // A non-M op passing through ID breaks adjacency.
  assign rec_load = accept & ~fusable;
  assign rec_inv  = flush | wd_fire | (accept & fusable) | (id_valid & ~id_rv32m & ~in_wait);

  rv32m_fuse_pred #(
    .ENABLE_FUSE (ENABLE_FUSE)
  ) u_pred (
    .clk     (clk),
    .clr     (clr),
    .load    (rec_load),
    .inv     (rec_inv),
    .func3   (id_func3),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .rd      (id_rd),
    .fusable (fusable)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= ST_IDLE;
      wd_cnt         <= 8'd0;
      e_rv32m        <= 1'b0;
      e_func3        <= 3'b000;
      fuse_hint      <= 1'b0;
      estart_sdivide <= 1'b0;
      estart_udivide <= 1'b0;
    end else begin
      estart_sdivide <= 1'b0;
      estart_udivide <= 1'b0;
      if (flush) begin
        state     <= ST_IDLE;
        wd_cnt    <= 8'd0;
        e_rv32m   <= 1'b0;
        fuse_hint <= 1'b0;
      end else if (accept) begin
        e_rv32m   <= 1'b1;
        e_func3   <= id_func3;
        fuse_hint <= fusable;
        wd_cnt    <= 8'd0;
        if (fusable) begin
          state <= ST_IDLE;
        end else begin
          state          <= id_func3[2] ? ST_DIV_WAIT : ST_MUL_WAIT;
          estart_sdivide <= id_func3[2] & ~id_func3[0];
          estart_udivide <= id_func3[2] & id_func3[0];
        end
      end else if (stall & ~wd_fire) begin
        wd_cnt <= wd_cnt + 8'd1;
      end else begin
        state     <= ST_IDLE;
        wd_cnt    <= 8'd0;
        e_rv32m   <= 1'b0;
        fuse_hint <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_issue_ctrl.sv
// Bench for rv32m_issue_ctrl: directed scenarios then random traffic, all checked
// against an outstanding-op reference model at every cycle.
module tb_rv32m_issue_ctrl;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       clr;
  logic       id_valid, id_rv32m, flush, ex_ready, ex_fuse;
  logic [2:0] id_func3;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       e_rv32m, estart_sdivide, estart_udivide, stall, fuse_hint, mismatch, timeout;
  logic [2:0] e_func3;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one outstanding op, its age, and the last unfused op seen.
  bit         m_busy;
  int         m_age;
  bit         r_valid;
  logic [2:0] r_f3;
  logic [4:0] r_rs1, r_rs2, r_rd;
  bit         x_e, x_fh, x_ss, x_su;
  logic [2:0] x_f3;

  always #5 clk = ~clk;

  rv32m_issue_ctrl #(
    .TIMEOUT     (TMO),
    .ENABLE_FUSE (1'b1)
  ) u_dut (
    .clk            (clk),
    .clr            (clr),
    .id_valid       (id_valid),
    .id_rv32m       (id_rv32m),
    .id_func3       (id_func3),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .flush          (flush),
    .ex_ready       (ex_ready),
    .ex_fuse        (ex_fuse),
    .e_rv32m        (e_rv32m),
    .e_func3        (e_func3),
    .estart_sdivide (estart_sdivide),
    .estart_udivide (estart_udivide),
    .stall          (stall),
    .fuse_hint      (fuse_hint),
    .mismatch       (mismatch),
    .timeout        (timeout)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pair_ok();
    bit kind;
    kind = ((r_f3 >= 3'd1 && r_f3 <= 3'd3) && id_func3 == 3'd0) ||
           (r_f3 == 3'd4 && id_func3 == 3'd6) || (r_f3 == 3'd5 && id_func3 == 3'd7);
    return r_valid && (r_rs1 == id_rs1) && (r_rs2 == id_rs2) &&
           (r_rd != r_rs1) && (r_rd != r_rs2) && kind;
  endfunction

  function automatic logic [2:0] partner(input logic [2:0] f);
    case (f)
      3'd1, 3'd2, 3'd3: return 3'd0;
      3'd4:             return 3'd6;
      3'd5:             return 3'd7;
      default:          return 3'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; r_valid = 0;
    r_f3 = 3'd0; r_rs1 = 5'd0; r_rs2 = 5'd0; r_rd = 5'd0;
    x_e = 0; x_fh = 0; x_ss = 0; x_su = 0; x_f3 = 3'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_e_rv32m"}, {7'd0, e_rv32m}, 8'd0);
    chk({tag, "_e_func3"}, {5'd0, e_func3}, 8'd0);
    chk({tag, "_estart"}, {6'd0, estart_sdivide, estart_udivide}, 8'd0);
    chk({tag, "_stall"}, {7'd0, stall}, 8'd0);
    chk({tag, "_hint"}, {7'd0, fuse_hint}, 8'd0);
    chk({tag, "_mis_tmo"}, {6'd0, mismatch, timeout}, 8'd0);
  endtask

  // Called just after a falling edge with inputs set; checks, advances model, ends on next falling edge.
  task automatic cycle();
    bit e_stall, e_tmo, e_mis, take, fz;
    #1;
    e_stall = m_busy && !ex_ready;
    e_tmo   = e_stall && (m_age == TMO - 1);
    e_mis   = ((m_busy && ex_ready) || (x_e && x_fh)) && (ex_fuse != x_fh);
    chk("stall", {7'd0, stall}, {7'd0, e_stall});
    chk("timeout", {7'd0, timeout}, {7'd0, e_tmo});
    chk("mismatch", {7'd0, mismatch}, {7'd0, e_mis});
    chk("e_rv32m", {7'd0, e_rv32m}, {7'd0, x_e});
    chk("e_func3", {5'd0, e_func3}, {5'd0, x_f3});
    chk("fuse_hint", {7'd0, fuse_hint}, {7'd0, x_fh});
    chk("estart_s", {7'd0, estart_sdivide}, {7'd0, x_ss});
    chk("estart_u", {7'd0, estart_udivide}, {7'd0, x_su});
    take = id_valid && id_rv32m && !e_stall && !flush;
    fz   = take && pair_ok();
    x_ss = take && !fz && (id_func3 == 3'd4 || id_func3 == 3'd6);
    x_su = take && !fz && (id_func3 == 3'd5 || id_func3 == 3'd7);
    if (flush) begin
      m_busy = 0; x_e = 0; x_fh = 0; m_age = 0; r_valid = 0;
    end else if (take) begin
      x_e = 1; x_f3 = id_func3; x_fh = fz; m_busy = !fz; m_age = 0;
      if (fz) r_valid = 0;
      else begin
        r_valid = 1; r_f3 = id_func3; r_rs1 = id_rs1; r_rs2 = id_rs2; r_rd = id_rd;
      end
    end else if (e_stall && !e_tmo) begin
      m_age++;
    end else begin
      if (e_tmo) r_valid = 0;
      if (!m_busy && id_valid && !id_rv32m) r_valid = 0;
      m_busy = 0; x_e = 0; x_fh = 0; m_age = 0;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    id_valid = 1; id_rv32m = 1; id_func3 = f3; id_rs1 = a; id_rs2 = b; id_rd = d;
    cycle();
    id_valid = 0; id_rv32m = 0;
  endtask

  task automatic wait_ready(input int n, input logic fz);
    ex_ready = 0;
    for (int i = 1; i < n; i++) cycle();
    ex_ready = 1; ex_fuse = fz;
    cycle();
    ex_ready = 0; ex_fuse = 0;
  endtask

  task automatic async_clear(input string tag);
    #2 clr = 1;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    clr = 0;
  endtask

  initial begin
    clr = 1; id_valid = 0; id_rv32m = 0; id_func3 = 3'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    flush = 0; ex_ready = 0; ex_fuse = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    clr = 0;
    cycle();

    // MULHU x7<-x5,x6 done at T+3, then MUL x8<-x5,x6 fuses
    issue(3'd3, 5'd5, 5'd6, 5'd7);
    chk("mulhu_stall", {7'd0, stall}, 8'd1);
    wait_ready(3, 1'b0);
    issue(3'd0, 5'd5, 5'd6, 5'd8);
    chk("fused_hint", {7'd0, fuse_hint}, 8'd1);
    chk("fused_start", {6'd0, estart_sdivide, estart_udivide}, 8'd0);
    ex_fuse = 1;
    cycle();
    ex_fuse = 0;

    // DIV x1<-x1,x2 then REM x3<-x1,x2: rd overwrote rs1, so no fusion
    issue(3'd4, 5'd1, 5'd2, 5'd1);
    wait_ready(5, 1'b0);
    issue(3'd6, 5'd1, 5'd2, 5'd3);
    chk("rem_start", {7'd0, estart_sdivide}, 8'd1);
    chk("rem_hint", {7'd0, fuse_hint}, 8'd0);
    wait_ready(4, 1'b0);

    // DIVU with completion at T+34
    issue(3'd5, 5'd10, 5'd11, 5'd9);
    chk("divu_start", {7'd0, estart_udivide}, 8'd1);
    wait_ready(34, 1'b0);
    cycle();

    // Flush at T+5 in DIV_WAIT; the would-be partner REM is not fused
    issue(3'd4, 5'd5, 5'd6, 5'd4);
    repeat (4) cycle();
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_e", {7'd0, e_rv32m}, 8'd0);
    issue(3'd6, 5'd5, 5'd6, 5'd7);
    chk("flush_nofuse", {7'd0, fuse_hint}, 8'd0);
    wait_ready(2, 1'b0);

    // Watchdog: no ex_ready at all
    issue(3'd4, 5'd5, 5'd6, 5'd4);
    repeat (TMO - 1) cycle();
    chk("tmo_pulse", {7'd0, timeout}, 8'd1);
    cycle();
    chk("tmo_stall", {7'd0, stall}, 8'd0);
    issue(3'd6, 5'd5, 5'd6, 5'd7);
    chk("tmo_nofuse", {7'd0, fuse_hint}, 8'd0);
    wait_ready(1, 1'b0);

    // A non-M op between MULH and MUL breaks the pair
    issue(3'd1, 5'd5, 5'd6, 5'd7);
    wait_ready(1, 1'b0);
    id_valid = 1; id_rv32m = 0;
    cycle();
    id_valid = 0;
    issue(3'd0, 5'd5, 5'd6, 5'd8);
    chk("nonm_nofuse", {7'd0, fuse_hint}, 8'd0);
    wait_ready(1, 1'b0);

    // clr mid DIV_WAIT
    issue(3'd4, 5'd5, 5'd6, 5'd4);
    repeat (3) cycle();
    async_clear("clr_div");

    // Fused op with ex_fuse forced wrong, then clr
    issue(3'd3, 5'd5, 5'd6, 5'd7);
    wait_ready(1, 1'b0);
    issue(3'd0, 5'd5, 5'd6, 5'd8);
    ex_fuse = 0;
    #1 chk("forced_mis", {7'd0, mismatch}, 8'd1);
    cycle();
    cycle();
    ex_fuse = 1;
    async_clear("clr_fused");
    ex_fuse = 0;
    cycle();

    // Random traffic; later chunk makes completions rare so the watchdog fires
    for (int k = 0; k < 1600; k++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rv32m = ($urandom_range(0, 5) != 0);
      if (r_valid && $urandom_range(0, 1) == 1) begin
        id_func3 = partner(r_f3); id_rs1 = r_rs1; id_rs2 = r_rs2;
      end else begin
        id_func3 = 3'($urandom_range(0, 7));
        id_rs1 = 5'($urandom_range(1, 3));
        id_rs2 = 5'($urandom_range(1, 3));
      end
      id_rd    = 5'($urandom_range(0, 4));
      flush    = ($urandom_range(0, 24) == 0);
      ex_ready = (k < 1100) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0);
      ex_fuse  = ($urandom_range(0, 3) == 0) ? !x_fh : x_fh;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
